// File: rtl/attention_av_stream.sv
// Signed attention A*V engine: accumulates L terms per output element with per-token
// operand precision, then streams rounded/saturated token rows out under valid/ready.
module attention_av_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(L)+1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]  V_in,
  input  logic [4*L-1:0]               token_precision,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(L)-1:0]         out_row,
  output logic [DATA_WIDTH*N*E-1:0]    out_data,
  output logic                         done
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = $clog2(L);
  localparam int NE = N*E;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic signed [ACC_WIDTH-1:0] RND     = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (DW-2);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] reduce_prec(input logic [DW-1:0] x, input logic [3:0] p);
    logic [DW-1:0] mask4;
    logic [DW-1:0] mask8;
    mask4 = {{4{1'b1}}, {(DW-4){1'b0}}};
    mask8 = {{8{1'b1}}, {(DW-8){1'b0}}};
    case (p)
      4'd0:    return x & mask4;
      4'd1:    return x & mask8;
      default: return x;
    endcase
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] mac_term(input logic [DW-1:0] a,
                                                           input logic [DW-1:0] v,
                                                           input logic [3:0]    p);
    logic signed [DW-1:0]   ar;
    logic signed [DW-1:0]   vr;
    logic signed [2*DW-1:0] prod;
    ar   = reduce_prec(a, p);
    vr   = reduce_prec(v, p);
    prod = ar * vr;
    return {{(ACC_WIDTH-2*DW){prod[2*DW-1]}}, prod};
  endfunction

  function automatic logic [DW-1:0] convert(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] r;
    sum = acc + RND;
    r   = sum >>> (DW-1);
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end else begin
      r = r;
    end
    return r[DW-1:0];
  endfunction

  logic [1:0]                    state_r;
  logic                          busy_r;
  logic                          out_valid_r;
  logic                          done_r;
  logic [RW-1:0]                 row_r;
  logic [RW-1:0]                 l2_cnt_r;
  logic [DW*NE-1:0]              out_data_r;
  logic [DW*L*N*L-1:0]           a_r;
  logic [DW*L*N*E-1:0]           v_r;
  logic [4*L-1:0]                prec_r;
  logic signed [ACC_WIDTH-1:0]   acc_r     [L*NE];
  logic signed [ACC_WIDTH-1:0]   acc_nxt_s [L*NE];
  logic [3:0]                    prec_s;
  logic [DW*NE-1:0]              conv_row_s;
  int                            sel_row_s;

  assign prec_s = prec_r[4*l2_cnt_r +: 4];

  // Accumulator next value: every element adds its l2 = l2_cnt term while in MUL.
  always_comb begin
    for (int l = 0; l < L; l++) begin
      for (int n = 0; n < N; n++) begin
        for (int e = 0; e < E; e++) begin
          if (state_r == ST_MUL) begin
            acc_nxt_s[(l*N+n)*E+e] = acc_r[(l*N+n)*E+e] +
              mac_term(a_r[((l*N+n)*L+int'(l2_cnt_r))*DW +: DW],
                       v_r[((int'(l2_cnt_r)*N+n)*E+e)*DW +: DW], prec_s);
          end else begin
            acc_nxt_s[(l*N+n)*E+e] = acc_r[(l*N+n)*E+e];
          end
        end
      end
    end
  end

  // Converted row that becomes visible next: row 0 on leaving MUL, else the following row.
  always_comb begin
    conv_row_s = '0;
    if (state_r == ST_MUL) begin
      sel_row_s = 0;
    end else begin
      sel_row_s = int'(row_r) + 1;
    end
    if (sel_row_s < L) begin
      for (int j = 0; j < NE; j++) begin
        conv_row_s[j*DW +: DW] = convert(acc_nxt_s[sel_row_s*NE + j]);
      end
    end else begin
      conv_row_s = '0;
    end
  end

  // Accumulator array: cleared on an accepted start, otherwise follows acc_nxt_s.
  always_ff @(posedge clk) begin
    if (rst || (state_r == ST_IDLE && start)) begin
      for (int i = 0; i < L*NE; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      acc_r <= acc_nxt_s;
    end
  end

  // Control FSM, operand capture and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      row_r       <= '0;
      l2_cnt_r    <= '0;
      out_data_r  <= '0;
      a_r         <= '0;
      v_r         <= '0;
      prec_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r      <= A_in;
            v_r      <= V_in;
            prec_r   <= token_precision;
            l2_cnt_r <= '0;
            busy_r   <= 1'b1;
            state_r  <= ST_MUL;
          end
        end
        ST_MUL: begin
          l2_cnt_r <= l2_cnt_r + RW'(1'b1);
          if (l2_cnt_r == RW'(L-1)) begin
            state_r     <= ST_OUT;
            out_valid_r <= 1'b1;
            row_r       <= '0;
            out_data_r  <= conv_row_s;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (row_r == RW'(L-1)) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b0;
              out_data_r  <= '0;
              row_r       <= '0;
              done_r      <= 1'b1;
            end else begin
              row_r      <= row_r + RW'(1'b1);
              out_data_r <= conv_row_s;
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_row   = row_r;
  assign out_data  = out_data_r;
  assign done      = done_r;

endmodule

// File: tb/tb_attention_av_stream.sv
// Directed bench for attention_av_stream (DATA_WIDTH=16, L=4, N=1, E=2).
module tb_attention_av_stream;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [255:0]  A_in;
  logic [127:0]  V_in;
  logic [15:0]   token_precision;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_row;
  logic [31:0]   out_data;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] v;
    logic [15:0] prec;
    logic [15:0] exp;
  } vec_t;

  vec_t         vecs [11];
  logic [255:0] diag_a;
  logic [127:0] diag_v;
  logic [127:0] exp_diag;

  attention_av_stream #(.DATA_WIDTH(16), .L(4), .N(1), .E(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A_in(A_in), .V_in(V_in),
    .token_precision(token_precision), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job: start pulse, optional stall on one row, optional stray start pulses.
  task automatic run_job(input string name, input logic [255:0] a, input logic [127:0] v,
                         input logic [15:0] p, input logic [127:0] exp,
                         input int stall_row, input int stall_n, input bit glitch);
    int cyc;
    int row_exp;
    int stalls;
    bit got_done;
    bit seen_valid;
    A_in = a; V_in = v; token_precision = p;
    start = 1'b1; out_ready = 1'b1;
    tick();
    cyc = 1; row_exp = 0; stalls = 0; got_done = 1'b0; seen_valid = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    while (cyc < 40 && !got_done) begin
      start = glitch && (cyc == 2 || cyc == 6);
      if (glitch && cyc == 2) begin
        A_in = ~a; V_in = ~v; token_precision = ~p;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (!seen_valid) begin
          check({name, "_first_valid_cyc"}, 64'(cyc), 64'd5);
          seen_valid = 1'b1;
        end
        check($sformatf("%s_row%0d_idx", name, row_exp), 64'(out_row), 64'(row_exp));
        check($sformatf("%s_row%0d_data", name, row_exp), 64'(out_data), 64'(exp[row_exp*32 +: 32]));
        if (row_exp == stall_row && stalls < stall_n) begin
          out_ready = 1'b0;
          stalls++;
        end
        if (out_ready) row_exp++;
      end else begin
        check({name, "_idle_data_zero"}, 64'(out_data), 64'd0);
      end
      if (done) begin
        check({name, "_done_cyc"}, 64'(cyc), 64'(9 + stall_n));
        check({name, "_rows_seen"}, 64'(row_exp), 64'd4);
        check({name, "_done_no_valid"}, 64'(out_valid), 64'd0);
        got_done = 1'b1;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (!got_done) check({name, "_timeout"}, 64'd0, 64'd1);
    check({name, "_back_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{16'h2000, 16'h4000, 16'h2222, 16'h4000};
    vecs[1]  = '{16'h20FF, 16'h4000, 16'h1111, 16'h4000};
    vecs[2]  = '{16'h20FF, 16'h4000, 16'h2222, 16'h41FE};
    vecs[3]  = '{16'h20FF, 16'h4000, 16'h2210, 16'h40FF};
    vecs[4]  = '{16'h20FF, 16'h4000, 16'h0000, 16'h4000};
    vecs[5]  = '{16'h20FF, 16'h4000, 16'h3F3F, 16'h41FE};
    vecs[6]  = '{16'h2000, 16'h40FF, 16'h1111, 16'h4000};
    vecs[7]  = '{16'h2000, 16'h40FF, 16'h2222, 16'h40FF};
    vecs[8]  = '{16'h7FFF, 16'h7FFF, 16'h2222, 16'h7FFF};
    vecs[9]  = '{16'h7FFF, 16'h8000, 16'h2222, 16'h8000};
    vecs[10] = '{16'hE000, 16'h4000, 16'h2222, 16'hC000};

    // Diagonal A (0.25 on l2==l) picks out V row l scaled by 1/4: distinct per row/element.
    for (int l = 0; l < 4; l++)
      for (int l2 = 0; l2 < 4; l2++)
        diag_a[(l*4+l2)*16 +: 16] = (l == l2) ? 16'h2000 : 16'h0000;
    for (int l = 0; l < 4; l++)
      for (int e = 0; e < 2; e++) begin
        diag_v[(l*2+e)*16 +: 16]   = 16'(16'h0400 * (l*2+e+1));
        exp_diag[l*32+e*16 +: 16]  = 16'(16'h0100 * (l*2+e+1));
      end

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    A_in = '0; V_in = '0; token_precision = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_row", 64'(out_row), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_job($sformatf("vec%0d", i), {16{vecs[i].a}}, {8{vecs[i].v}}, vecs[i].prec,
              {8{vecs[i].exp}}, -1, 0, 1'b0);
    end

    run_job("diag", diag_a, diag_v, 16'h2222, exp_diag, -1, 0, 1'b0);
    run_job("backpressure", diag_a, diag_v, 16'h2222, exp_diag, 1, 3, 1'b0);
    run_job("stray_start", diag_a, diag_v, 16'h2222, exp_diag, -1, 0, 1'b1);

    // Reset asserted during MUL cycle 2 aborts the job without a done pulse.
    begin
      int done_cnt;
      int valid_cnt;
      A_in = diag_a; V_in = diag_v; token_precision = 16'h2222;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("mulrst_busy", 64'(busy), 64'd0);
      check("mulrst_valid", 64'(out_valid), 64'd0);
      check("mulrst_data", 64'(out_data), 64'd0);
      rst = 1'b0;
      done_cnt = 0; valid_cnt = 0;
      for (int k = 0; k < 12; k++) begin
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
        tick();
      end
      check("mulrst_no_done", 64'(done_cnt), 64'd0);
      check("mulrst_no_valid", 64'(valid_cnt), 64'd0);
    end
    run_job("after_rst", diag_a, diag_v, 16'h2222, exp_diag, -1, 0, 1'b0);

    // start held high: job 2 (diag) is accepted in cycle 10 from inputs present then.
    begin
      logic [127:0] exp1;
      bit exp_valid;
      bit exp_busy;
      exp1 = {8{16'h4000}};
      A_in = {16{16'h2000}}; V_in = {8{16'h4000}}; token_precision = 16'h2222;
      start = 1'b1; out_ready = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 22; cyc++) begin
        if (cyc == 5) begin
          A_in = diag_a; V_in = diag_v;
        end
        if (cyc == 11) start = 1'b0;
        exp_valid = (cyc >= 5 && cyc <= 8) || (cyc >= 15 && cyc <= 18);
        exp_busy  = (cyc >= 1 && cyc <= 9) || (cyc >= 11 && cyc <= 19);
        check($sformatf("b2b_valid_c%0d", cyc), 64'(out_valid), 64'(exp_valid));
        check($sformatf("b2b_busy_c%0d", cyc), 64'(busy), 64'(exp_busy));
        check($sformatf("b2b_done_c%0d", cyc), 64'(done), 64'(cyc == 9 || cyc == 19));
        if (exp_valid && cyc <= 8) begin
          check($sformatf("b2b_row_c%0d", cyc), 64'(out_row), 64'(cyc-5));
          check($sformatf("b2b_data_c%0d", cyc), 64'(out_data), 64'(exp1[(cyc-5)*32 +: 32]));
        end else if (exp_valid) begin
          check($sformatf("b2b_row_c%0d", cyc), 64'(out_row), 64'(cyc-15));
          check($sformatf("b2b_data_c%0d", cyc), 64'(out_data), 64'(exp_diag[(cyc-15)*32 +: 32]));
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
